// File: rtl/ula_pkg.sv
// Shared constants for the multi-cycle ALU: op codes, FSM encoding and default width.
package ula_pkg;

    localparam int unsigned XlenDefault = 64;

    // ADD and SUB keep the codes the existing ALU control already emits.
    localparam logic [4:0] OpAnd  = 5'd0;
    localparam logic [4:0] OpOr   = 5'd1;
    localparam logic [4:0] OpAdd  = 5'd2;
    localparam logic [4:0] OpXor  = 5'd3;
    localparam logic [4:0] OpSub  = 5'd6;
    localparam logic [4:0] OpSlt  = 5'd7;
    localparam logic [4:0] OpSltu = 5'd8;
    localparam logic [4:0] OpBeq  = 5'd16;
    localparam logic [4:0] OpBne  = 5'd17;
    localparam logic [4:0] OpBlt  = 5'd20;
    localparam logic [4:0] OpBge  = 5'd21;
    localparam logic [4:0] OpBltu = 5'd22;
    localparam logic [4:0] OpBgeu = 5'd23;
    localparam logic [4:0] OpMul  = 5'd24;
    localparam logic [4:0] OpDiv  = 5'd25;
    localparam logic [4:0] OpDivu = 5'd26;
    localparam logic [4:0] OpRem  = 5'd27;
    localparam logic [4:0] OpRemu = 5'd28;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic logic is_iter(input logic [4:0] op);
        return (op == OpMul) || (op == OpDiv) || (op == OpDivu) ||
               (op == OpRem) || (op == OpRemu);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/ula_mdu_iter.sv
// Iterative multiply / restoring-divide engine: one bit per step, shared adder.
module ula_mdu_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            cnt_done_o,
    output logic [XLEN-1:0] res_o,
    output logic [XLEN-1:0] rem_o
);

    localparam int unsigned CntW = $clog2(XLEN);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [XLEN:0] rem_shift, add_a, add_b, sum;
    logic          q_bit;

    always_comb begin
        rem_shift = {hi_q, lo_q[XLEN-1]};
        // Divide subtracts via ~opd + 1; multiply adds opd when the current multiplier bit is set.
        add_a = is_div_i ? rem_shift : {1'b0, hi_q};
        add_b = is_div_i ? ~{1'b0, opd_q} : {1'b0, (lo_q[0] ? opd_q : {XLEN{1'b0}})};
        sum   = add_a + add_b + {{XLEN{1'b0}}, is_div_i};
        q_bit = ~sum[XLEN];

        hi_d  = hi_q;
        lo_d  = lo_q;
        opd_d = opd_q;
        cnt_d = cnt_q;
        if (load_i) begin
            hi_d  = '0;
            lo_d  = a_i;
            opd_d = b_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_i) begin
                hi_d = q_bit ? sum[XLEN-1:0] : rem_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], q_bit};
            end else begin
                hi_d  = sum[XLEN-1:0];
                lo_d  = lo_q >> 1;
                opd_d = opd_q << 1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opd_q <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            opd_q <= opd_d;
            cnt_q <= cnt_d;
        end
    end

    // Results are taken from next-state so the final step and output capture share one edge.
    assign cnt_done_o = (cnt_q == CntW'(XLEN - 1));
    assign res_o      = is_div_i ? lo_d : hi_d;
    assign rem_o      = hi_d;

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/compare/branch ops plus iterative MUL/DIV/REM.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault,
    parameter int unsigned OP_W = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] resultado,
    output logic            flag
);

    logic [1:0]      state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            flag_q, flag_d;

    logic [4:0]      op_s;
    logic [XLEN-1:0] diff;
    logic            lt_s, lt_u;
    logic [XLEN-1:0] sc_res;
    logic            sc_flag;

    logic            signed_div;
    logic [XLEN-1:0] load_a, load_b;
    logic            mdu_load, mdu_step, mdu_last;
    logic [XLEN-1:0] mdu_res, mdu_rem;
    logic [XLEN-1:0] fix_res;
    logic            b_zero, ovf;

    assign op_s = op[4:0];

    // Single-cycle datapath works on the live inputs; it is captured on the accepting edge.
    always_comb begin
        diff    = a - b;
        lt_s    = $signed(a) < $signed(b);
        lt_u    = a < b;
        sc_res  = '0;
        sc_flag = 1'b0;
        case (op_s)
            OpAdd:  sc_res = a + b;
            OpSub:  sc_res = diff;
            OpAnd:  sc_res = a & b;
            OpOr:   sc_res = a | b;
            OpXor:  sc_res = a ^ b;
            OpSlt:  sc_res = {{(XLEN-1){1'b0}}, lt_s};
            OpSltu: sc_res = {{(XLEN-1){1'b0}}, lt_u};
            OpBeq:  begin sc_res = diff; sc_flag = (a == b); end
            OpBne:  begin sc_res = diff; sc_flag = (a != b); end
            OpBlt:  begin sc_res = diff; sc_flag = lt_s;     end
            OpBge:  begin sc_res = diff; sc_flag = !lt_s;    end
            OpBltu: begin sc_res = diff; sc_flag = lt_u;     end
            OpBgeu: begin sc_res = diff; sc_flag = !lt_u;    end
            default: ;
        endcase
    end

    // Signed division runs on magnitudes; signs are restored from a_q/b_q at the end.
    always_comb begin
        signed_div = (op_s == OpDiv) || (op_s == OpRem);
        load_a     = (signed_div && a[XLEN-1]) ? -a : a;
        load_b     = (signed_div && b[XLEN-1]) ? -b : b;
    end

    ula_mdu_iter #(
        .XLEN(XLEN)
    ) u_mdu (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .load_i    (mdu_load),
        .step_i    (mdu_step),
        .is_div_i  (is_div_op(op_q)),
        .a_i       (load_a),
        .b_i       (load_b),
        .cnt_done_o(mdu_last),
        .res_o     (mdu_res),
        .rem_o     (mdu_rem)
    );

    always_comb begin
        b_zero  = (b_q == '0);
        ovf     = (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        fix_res = mdu_res;
        case (op_q)
            OpDivu: fix_res = b_zero ? '1 : mdu_res;
            OpRemu: fix_res = b_zero ? a_q : mdu_rem;
            OpDiv: begin
                if (b_zero)                      fix_res = '1;
                else if (ovf)                    fix_res = a_q;
                else if (a_q[XLEN-1] ^ b_q[XLEN-1]) fix_res = -mdu_res;
                else                             fix_res = mdu_res;
            end
            OpRem: begin
                if (b_zero)           fix_res = a_q;
                else if (ovf)         fix_res = '0;
                else if (a_q[XLEN-1]) fix_res = -mdu_rem;
                else                  fix_res = mdu_rem;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        flag_d   = flag_q;
        mdu_load = 1'b0;
        mdu_step = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    op_d = op_s;
                    a_d  = a;
                    b_d  = b;
                    if (is_iter(op_s)) begin
                        state_d  = StCalc;
                        mdu_load = 1'b1;
                    end else begin
                        state_d = StDone;
                        res_d   = sc_res;
                        flag_d  = sc_flag;
                    end
                end
            end
            StCalc: begin
                mdu_step = 1'b1;
                if (mdu_last) begin
                    state_d = StDone;
                    res_d   = fix_res;
                    flag_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
        end
    end

    assign busy      = (state_q == StCalc);
    assign done      = (state_q == StDone);
    assign resultado = res_q;
    assign flag      = flag_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo with hand-computed expectations.
module tb_ula_multiciclo;
    import ula_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [4:0]  op;
    logic [63:0] a, b;
    logic        busy, done, flag;
    logic [63:0] resultado;

    int n_checks = 0;
    int n_pass   = 0;

    ula_multiciclo #(
        .XLEN(64),
        .OP_W(5)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .resultado(resultado),
        .flag     (flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Issues one op and waits (bounded) for done; lat counts negedges from the accept edge.
    task automatic run_op(input logic [4:0] o, input logic [63:0] x, input logic [63:0] y,
                          output int lat, output int bcnt);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock);
        start = 1'b0;
        lat = 0; bcnt = 0;
        for (int i = 1; i <= 300; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
            @(negedge clock);
        end
    endtask

    int lat, bcnt, seen;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res",  resultado, 64'd0);
        check("rst_flag", 64'(flag), 64'd0);
        reset_n = 1'b1;

        run_op(OpAdd, 64'd45, 64'd11, lat, bcnt);
        check("add_lat",  64'(lat), 64'd1);
        check("add_res",  resultado, 64'd56);
        check("add_flag", 64'(flag), 64'd0);
        @(negedge clock);
        check("add_done_pulse", 64'(done), 64'd0);

        run_op(OpSub, 64'd45, 64'd11, lat, bcnt);
        check("sub_res", resultado, 64'd34);
        run_op(OpXor, 64'hF0F0, 64'h0FF0, lat, bcnt);
        check("xor_res", resultado, 64'hFF00);
        run_op(OpSlt, 64'(-3), 64'd2, lat, bcnt);
        check("slt_res", resultado, 64'd1);
        run_op(OpSltu, 64'(-3), 64'd2, lat, bcnt);
        check("sltu_res", resultado, 64'd0);

        run_op(OpBltu, 64'd1, 64'(-1), lat, bcnt);
        check("bltu_flag", 64'(flag), 64'd1);
        check("bltu_res",  resultado, 64'd2);
        run_op(OpBlt, 64'd1, 64'(-1), lat, bcnt);
        check("blt_flag", 64'(flag), 64'd0);
        run_op(OpBeq, 64'd14, 64'd14, lat, bcnt);
        check("beq_flag", 64'(flag), 64'd1);
        check("beq_res",  resultado, 64'd0);
        run_op(5'd31, 64'd9, 64'd4, lat, bcnt);
        check("unk_res",  resultado, 64'd0);
        check("unk_flag", 64'(flag), 64'd0);

        run_op(OpMul, 64'd3, 64'(-5), lat, bcnt);
        check("mul_busy_cycles", 64'(bcnt), 64'd64);
        check("mul_lat", 64'(lat), 64'd65);
        check("mul_res", resultado, 64'hFFFF_FFFF_FFFF_FFF1);

        run_op(OpDiv, 64'(-7), 64'd2, lat, bcnt);
        check("div_neg", resultado, 64'(-3));
        run_op(OpRem, 64'(-7), 64'd2, lat, bcnt);
        check("rem_neg", resultado, 64'(-1));
        run_op(OpDivu, 64'd100, 64'd7, lat, bcnt);
        check("divu", resultado, 64'd14);
        run_op(OpRemu, 64'd100, 64'd7, lat, bcnt);
        check("remu", resultado, 64'd2);
        run_op(OpDivu, 64'd100, 64'd0, lat, bcnt);
        check("divu_zero", resultado, 64'hFFFF_FFFF_FFFF_FFFF);
        check("divu_zero_lat", 64'(lat), 64'd65);
        run_op(OpRemu, 64'd100, 64'd0, lat, bcnt);
        check("remu_zero", resultado, 64'd100);
        run_op(OpDiv, 64'h8000_0000_0000_0000, 64'(-1), lat, bcnt);
        check("div_ovf", resultado, 64'h8000_0000_0000_0000);
        run_op(OpRem, 64'h8000_0000_0000_0000, 64'(-1), lat, bcnt);
        check("rem_ovf", resultado, 64'd0);

        // Start pulse with another op mid-calculation must be ignored.
        @(negedge clock);
        start = 1'b1; op = OpDiv; a = 64'd100; b = 64'd7;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (i == 10) begin
                start = 1'b1; op = OpAdd; a = 64'd1; b = 64'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check("ignore_lat", 64'(lat), 64'd65);
        check("ignore_res", resultado, 64'd14);

        // Back-to-back: new single-cycle start in the DONE cycle.
        start = 1'b1; op = OpAdd; a = 64'd5; b = 64'd6;
        @(negedge clock);
        start = 1'b0;
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_res",  resultado, 64'd11);
        @(negedge clock);
        check("b2b_done_end", 64'(done), 64'd0);

        // Reset during a divide aborts it.
        @(negedge clock);
        start = 1'b1; op = OpDiv; a = 64'd1000; b = 64'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_res",  resultado, 64'd0);
        check("mid_rst_flag", 64'(flag), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (70) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        check("no_done_after_abort", 64'(seen), 64'd0);
        run_op(OpAdd, 64'd2, 64'd3, lat, bcnt);
        check("post_rst_lat", 64'(lat), 64'd1);
        check("post_rst_res", resultado, 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
